// File: rtl/cordic_pkg.sv
// Shared CORDIC types and fixed-point constants: the atan(2^-i) table, CORDIC gain K, pi and pi/2.
// All constants are computed at elaboration for the requested FRAC and rounded to nearest.
package cordic_pkg;

    typedef enum logic [1:0] {
        OP_SIN  = 2'd0,
        OP_COS  = 2'd1,
        OP_ATAN = 2'd2
    } cordic_op_e;

    typedef struct packed {
        logic       valid;
        cordic_op_e op;
        logic       negate;
    } stage_ctrl_t;

    localparam real PI_R = 3.14159265358979323846;

    function automatic logic [63:0] to_fixed(input real v, input int unsigned frac);
        real scale;
        scale = 1.0;
        for (int unsigned i = 0; i < frac; i++) begin
            scale = scale * 2.0;
        end
        return 64'(longint'(v * scale));
    endfunction

    // Entry s of the atan table: atan(2^-s) in radians.
    function automatic logic [63:0] atan_fixed(input int unsigned s, input int unsigned frac);
        real t;
        t = 1.0;
        for (int unsigned i = 0; i < s; i++) begin
            t = t / 2.0;
        end
        return to_fixed($atan(t), frac);
    endfunction

    // Product of 1/sqrt(1+2^-2i) over all iterations, preloaded into x so results need no rescale.
    function automatic logic [63:0] gain_fixed(input int unsigned iters, input int unsigned frac);
        real k;
        real t;
        k = 1.0;
        t = 1.0;
        for (int unsigned i = 0; i < iters; i++) begin
            k = k / $sqrt(1.0 + t * t);
            t = t / 2.0;
        end
        return to_fixed(k, frac);
    endfunction

    function automatic logic [63:0] pi_fixed(input int unsigned frac);
        return to_fixed(PI_R, frac);
    endfunction

    function automatic logic [63:0] half_pi_fixed(input int unsigned frac);
        return to_fixed(PI_R / 2.0, frac);
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One CORDIC micro-rotation followed by its pipeline register.
// Vectoring direction (ATAN) is selectable only when CORDIC_VECTOR_EN is defined.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int unsigned      WIDTH         = 64,
    parameter int unsigned      SHIFT         = 0,
    parameter logic [WIDTH-1:0] ATAN_CONST    = '0,
    parameter int unsigned      TRANS_ID_BITS = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  stage_ctrl_t              ctrl_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    input  logic [WIDTH-1:0]         x_i,
    input  logic [WIDTH-1:0]         y_i,
    input  logic [WIDTH-1:0]         z_i,
    output stage_ctrl_t              ctrl_o,
    output logic [TRANS_ID_BITS-1:0] trans_id_o,
    output logic [WIDTH-1:0]         x_o,
    output logic [WIDTH-1:0]         y_o,
    output logic [WIDTH-1:0]         z_o
);

    logic [WIDTH-1:0] x_sh_c;
    logic [WIDTH-1:0] y_sh_c;
    logic [WIDTH-1:0] x_nxt_c;
    logic [WIDTH-1:0] y_nxt_c;
    logic [WIDTH-1:0] z_nxt_c;
    logic             ccw_c;

    // ccw_c set means rotate by +atan(2^-SHIFT); adds wrap modulo 2^WIDTH.
    always_comb begin
        x_sh_c = WIDTH'($signed(x_i) >>> SHIFT);
        y_sh_c = WIDTH'($signed(y_i) >>> SHIFT);
`ifdef CORDIC_VECTOR_EN
        ccw_c  = (ctrl_i.op == OP_ATAN) ? y_i[WIDTH-1] : ~z_i[WIDTH-1];
`else
        ccw_c  = ~z_i[WIDTH-1];
`endif
        if (ccw_c) begin
            x_nxt_c = x_i - y_sh_c;
            y_nxt_c = y_i + x_sh_c;
            z_nxt_c = z_i - ATAN_CONST;
        end else begin
            x_nxt_c = x_i + y_sh_c;
            y_nxt_c = y_i - x_sh_c;
            z_nxt_c = z_i + ATAN_CONST;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ctrl_o     <= '0;
            trans_id_o <= '0;
            x_o        <= '0;
            y_o        <= '0;
            z_o        <= '0;
        end else begin
            ctrl_o.valid  <= ctrl_i.valid & ~flush_i;
            ctrl_o.op     <= ctrl_i.op;
            ctrl_o.negate <= ctrl_i.negate;
            trans_id_o    <= trans_id_i;
            x_o           <= x_nxt_c;
            y_o           <= y_nxt_c;
            z_o           <= z_nxt_c;
        end
    end

endmodule

// File: rtl/cordic_pipe.sv
// Fully pipelined CORDIC unit: SIN/COS by rotation, ATAN2 by vectoring, ITERS+1 cycles latency.
// Define CORDIC_VECTOR_EN to build the ATAN datapath; without it ATAN returns 0 with normal latency.
module cordic_pipe
    import cordic_pkg::*;
#(
    parameter int unsigned WIDTH         = 64,
    parameter int unsigned FRAC          = 32,
    parameter int unsigned ITERS         = 16,
    parameter int unsigned TRANS_ID_BITS = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  cordic_op_e               op_i,
    input  logic [WIDTH-1:0]         operand_a_i,
    input  logic [WIDTH-1:0]         operand_b_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic                     valid_o,
    output logic [WIDTH-1:0]         result_o,
    output logic [TRANS_ID_BITS-1:0] trans_id_o
);

    localparam logic [WIDTH-1:0] K_C       = WIDTH'(gain_fixed(ITERS, FRAC));
    localparam logic [WIDTH-1:0] PI_C      = WIDTH'(pi_fixed(FRAC));
    localparam logic [WIDTH-1:0] HALF_PI_C = WIDTH'(half_pi_fixed(FRAC));

    // Index 0 is the combinational initial vector; 1..ITERS are stage registers.
    stage_ctrl_t              ctrl_s [ITERS+1];
    logic [TRANS_ID_BITS-1:0] tid_s  [ITERS+1];
    logic [WIDTH-1:0]         x_s    [ITERS+1];
    logic [WIDTH-1:0]         y_s    [ITERS+1];
    logic [WIDTH-1:0]         z_s    [ITERS+1];

    stage_ctrl_t      ctrl0_c;
    logic [WIDTH-1:0] x0_c;
    logic [WIDTH-1:0] y0_c;
    logic [WIDTH-1:0] z0_c;
    logic [WIDTH-1:0] res_c;
    logic             out_valid_c;

    assign ready_o = rst_ni & ~flush_i;

    // Initial vector: fold rotation angles into [-pi/2, pi/2], move ATAN vectors into x >= 0.
    always_comb begin
        ctrl0_c       = '0;
        ctrl0_c.valid = valid_i & ready_o;
        ctrl0_c.op    = op_i;
        x0_c          = '0;
        y0_c          = '0;
        z0_c          = '0;
        case (op_i)
            OP_ATAN: begin
`ifdef CORDIC_VECTOR_EN
                x0_c = operand_a_i;
                y0_c = operand_b_i;
                if (operand_a_i[WIDTH-1]) begin
                    x0_c = -operand_a_i;
                    y0_c = -operand_b_i;
                    z0_c = operand_b_i[WIDTH-1] ? -PI_C : PI_C;
                end
`endif
            end
            default: begin
                x0_c = K_C;
                z0_c = operand_a_i;
                if ($signed(operand_a_i) > $signed(HALF_PI_C)) begin
                    z0_c           = operand_a_i - PI_C;
                    ctrl0_c.negate = 1'b1;
                end else if ($signed(operand_a_i) < -$signed(HALF_PI_C)) begin
                    z0_c           = operand_a_i + PI_C;
                    ctrl0_c.negate = 1'b1;
                end
            end
        endcase
    end

`ifndef CORDIC_VECTOR_EN
    logic unused_c;
    assign unused_c = ^{operand_b_i, z_s[ITERS]};
`endif

    assign ctrl_s[0] = ctrl0_c;
    assign tid_s[0]  = trans_id_i;
    assign x_s[0]    = x0_c;
    assign y_s[0]    = y0_c;
    assign z_s[0]    = z0_c;

    for (genvar g = 0; g < ITERS; g = g + 1) begin : g_stage
        cordic_stage #(
            .WIDTH         (WIDTH),
            .SHIFT         (g),
            .ATAN_CONST    (WIDTH'(atan_fixed(g, FRAC))),
            .TRANS_ID_BITS (TRANS_ID_BITS)
        ) u_stage (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .flush_i    (flush_i),
            .ctrl_i     (ctrl_s[g]),
            .trans_id_i (tid_s[g]),
            .x_i        (x_s[g]),
            .y_i        (y_s[g]),
            .z_i        (z_s[g]),
            .ctrl_o     (ctrl_s[g+1]),
            .trans_id_o (tid_s[g+1]),
            .x_o        (x_s[g+1]),
            .y_o        (y_s[g+1]),
            .z_o        (z_s[g+1])
        );
    end

    // Result select from the last stage, undoing the angle fold when negate is set.
    always_comb begin
        res_c       = '0;
        out_valid_c = ctrl_s[ITERS].valid & ~flush_i;
        case (ctrl_s[ITERS].op)
            OP_SIN:  res_c = ctrl_s[ITERS].negate ? -y_s[ITERS] : y_s[ITERS];
            OP_COS:  res_c = ctrl_s[ITERS].negate ? -x_s[ITERS] : x_s[ITERS];
`ifdef CORDIC_VECTOR_EN
            OP_ATAN: res_c = z_s[ITERS];
`endif
            default: res_c = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_o    <= 1'b0;
            result_o   <= '0;
            trans_id_o <= '0;
        end else begin
            valid_o    <= out_valid_c;
            result_o   <= out_valid_c ? res_c : '0;
            trans_id_o <= out_valid_c ? tid_s[ITERS] : '0;
        end
    end

endmodule
